stopwatch_counter: RTL and testbench

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_counter.sv | 97 +++++++++
 tb/tb_stopwatch_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: mm:ss.cc BCD stopwatch driven by a resynchronized 100 Hz base tick.
// Define STOPWATCH_LAP_EN to build the lap-freeze display snapshot.
`timescale 1ns/1ps
module stopwatch_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_sclk,
    input  logic       i_reset_n,
    input  logic       i_basetick,
    input  logic       i_start_stop,
    input  logic       i_clear,
    input  logic       i_lap,
    output logic       o_timerenb,
    output logic [3:0] o_cs_ones,
    output logic [3:0] o_cs_tens,
    output logic [3:0] o_sec_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_min_tens,
    output logic       o_running,
    output logic       o_lap_active,
    output logic       o_overflow
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    // digit limits, index 0 = cs_ones ... index 5 = min_tens
    localparam logic [5:0][3:0] LIM = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    state_t                 state, n_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q, tick, inc, wrap, running_q, overflow_q;
    logic [5:0][3:0]        cnt, n_cnt, disp;

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_basetick};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign inc  = tick & (state == RUN) & ~i_clear;

    always_comb begin
        n_state = i_clear ? IDLE : !i_start_stop ? state : (state == RUN) ? PAUSE : RUN;
        n_cnt   = cnt;
        wrap    = inc;
        for (int i = 0; i < 6; i++) begin
            n_cnt[i] = i_clear ? 4'd0 : !wrap ? cnt[i] : (cnt[i] == LIM[i]) ? 4'd0 : cnt[i] + 4'd1;
            wrap     = wrap & (cnt[i] == LIM[i]);
        end
    end

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= n_state;
            cnt        <= n_cnt;
            running_q  <= (n_state == RUN);
            overflow_q <= wrap;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_q, n_lap;
    assign n_lap = !i_clear && (lap_q ^ (i_lap && state != IDLE));

    // display follows the next live count unless frozen, so it stays registered
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lap_q <= 1'b0;
            disp  <= '0;
        end else begin
            lap_q <= n_lap;
            disp  <= n_lap ? disp : n_cnt;
        end
    end

    assign o_lap_active = lap_q;
`else
    logic lap_unused;
    assign lap_unused   = i_lap;
    assign disp         = cnt;
    assign o_lap_active = 1'b0;
`endif

    assign {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_cs_tens, o_cs_ones} = disp;
    assign o_running  = running_q;
    assign o_timerenb = running_q;
    assign o_overflow = overflow_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: scoreboard bench for stopwatch_counter; expectations come from a centisecond model.
`timescale 1ns/1ps
module tb_stopwatch_counter;
    logic       i_sclk = 1'b0, i_reset_n = 1'b0, i_basetick = 1'b0;
    logic       i_start_stop = 1'b0, i_clear = 1'b0, i_lap = 1'b0;
    logic       o_timerenb, o_running, o_lap_active, o_overflow;
    logic [3:0] o_cs_ones, o_cs_tens, o_sec_ones, o_sec_tens, o_min_ones, o_min_tens;

    typedef struct {string name; logic [27:0] val;} exp_t;
    exp_t sb[$];
    exp_t e;
    int   checks = 0, failures = 0, model_cs = 0;

    stopwatch_counter #(.SYNC_STAGES(2)) dut (
        .i_sclk(i_sclk), .i_reset_n(i_reset_n), .i_basetick(i_basetick),
        .i_start_stop(i_start_stop), .i_clear(i_clear), .i_lap(i_lap),
        .o_timerenb(o_timerenb), .o_cs_ones(o_cs_ones), .o_cs_tens(o_cs_tens),
        .o_sec_ones(o_sec_ones), .o_sec_tens(o_sec_tens), .o_min_ones(o_min_ones),
        .o_min_tens(o_min_tens), .o_running(o_running), .o_lap_active(o_lap_active),
        .o_overflow(o_overflow)
    );

    always #5 i_sclk = ~i_sclk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within 1 ms");
        $fatal(1, "timeout");
    end

    function automatic logic [23:0] to_bcd(int cs);
        int m = (cs / 6000) % 60, s = (cs / 100) % 60, c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [27:0] expv(int cs, bit run, bit lap_cs_valid, int lap_cs, bit ovf);
        return {to_bcd(lap_cs_valid ? lap_cs : cs), run, run, lap_cs_valid, ovf};
    endfunction

    function automatic logic [27:0] observed();
        return {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_cs_tens, o_cs_ones,
                o_timerenb, o_running, o_lap_active, o_overflow};
    endfunction

    task automatic pulse_start();
        @(negedge i_sclk) i_start_stop = 1'b1;
        @(negedge i_sclk) i_start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge i_sclk) i_clear = 1'b1;
        @(negedge i_sclk) i_clear = 1'b0;
    endtask

    task automatic pulse_lap();
        @(negedge i_sclk) i_lap = 1'b1;
        @(negedge i_sclk) i_lap = 1'b0;
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            @(negedge i_sclk) i_basetick = 1'b1;
            @(negedge i_sclk) i_basetick = 1'b0;
        end
        repeat (4) @(negedge i_sclk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_sclk);
        sb.push_back('{name: "reset_state", val: expv(0, 0, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        i_reset_n = 1'b1;
    endtask

    task automatic test_run();
        i_basetick = 1'b1;
        repeat (5) @(negedge i_sclk);
        pulse_start();
        repeat (5) @(negedge i_sclk);
        sb.push_back('{name: "start_high_base", val: expv(0, 1, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        i_basetick = 1'b0;
        ticks(150);
        model_cs = 150;
        sb.push_back('{name: "run_150", val: expv(model_cs, 1, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
    endtask

    task automatic test_pause();
        pulse_clear();
        model_cs = 0;
        sb.push_back('{name: "clear_idle", val: expv(0, 0, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        ticks(3);
        sb.push_back('{name: "idle_ignores", val: expv(0, 0, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        pulse_start();
        ticks(20);
        model_cs = 20;
        pulse_start();
        ticks(5);
        sb.push_back('{name: "pause_hold", val: expv(model_cs, 0, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        pulse_start();
        ticks(3);
        model_cs = 23;
        sb.push_back('{name: "resume", val: expv(model_cs, 1, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
    endtask

    task automatic test_clear_priority();
        ticks(177);
        model_cs = 200;
        sb.push_back('{name: "reach_2s", val: expv(model_cs, 1, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        // tick pulse lands on the same edge as clear+start_stop
        @(negedge i_sclk) i_basetick = 1'b1;
        @(negedge i_sclk);
        @(negedge i_sclk) begin i_clear = 1'b1; i_start_stop = 1'b1; end
        @(negedge i_sclk) begin i_clear = 1'b0; i_start_stop = 1'b0; i_basetick = 1'b0; end
        model_cs = 0;
        sb.push_back('{name: "clear_priority", val: expv(0, 0, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        repeat (4) @(negedge i_sclk);
        sb.push_back('{name: "clear_settled", val: expv(0, 0, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
    endtask

    task automatic test_overflow();
        int ovf_cycles = 0;
        pulse_start();
        @(negedge i_sclk) force dut.cnt = 24'h595999;
        @(negedge i_sclk) release dut.cnt;
        model_cs = 359999;
        sb.push_back('{name: "preload", val: expv(model_cs, 1, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        i_basetick = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_sclk);
            if (k == 0) i_basetick = 1'b0;
            if (o_overflow) ovf_cycles++;
        end
        checks++;
        if (ovf_cycles !== 1) begin failures++; $display("FAIL overflow_pulse: got %0d cycles expected 1", ovf_cycles); end
        model_cs = 0;
        sb.push_back('{name: "wrap", val: expv(model_cs, 1, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
    endtask

    task automatic test_lap();
        bit lap_on = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_on = 1'b1;
`endif
        ticks(40);
        model_cs = 40;
        pulse_lap();
        ticks(60);
        model_cs = 100;
        sb.push_back('{name: "lap_frozen", val: expv(model_cs, 1, lap_on, 40, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        pulse_lap();
        sb.push_back('{name: "lap_release", val: expv(model_cs, 1, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
    endtask

    task automatic test_async_reset();
        ticks(1134);
        model_cs = 1234;
        sb.push_back('{name: "reach_12_34", val: expv(model_cs, 1, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        @(negedge i_sclk);
        #2 i_reset_n = 1'b0;
        #1;
        model_cs = 0;
        sb.push_back('{name: "async_reset", val: expv(0, 0, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        @(negedge i_sclk) i_reset_n = 1'b1;
        pulse_start();
        sb.push_back('{name: "restart_zero", val: expv(0, 1, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
        ticks(1);
        model_cs = 1;
        sb.push_back('{name: "restart_tick", val: expv(model_cs, 1, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (observed() !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, observed(), e.val); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause();
        test_clear_priority();
        test_overflow();
        test_lap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
